// File: rtl/c16_tape_player.sv
// TAP cassette playback source: pulls TAP v0/v1 bytes over ready/valid and
// rebuilds the low/high pulse train on cass_read, paced by ce and gated by the motor.
module c16_tape_player #(
  parameter int SCALE = 8,
  parameter int CNT_W = 24   // must be >= 24 to hold a full v1 extended length
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       motor_n,
  input  logic       play,
  input  logic       tap_ver1,
  input  logic [7:0] tap_data,
  input  logic       tap_valid,
  output logic       tap_ready,
  output logic       cass_read,
  output logic       sense_n,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, FETCH, EXT0, EXT1, EXT2, RUN_LO, RUN_HI} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_len;
  logic               r_cass;
  logic [CNT_W-1:0]   w_raw;
  logic [CNT_W-1:0]   w_len;
  logic [CNT_W-1:0]   w_hi;
  logic               w_tick;

  // Candidate pulse length for whichever byte is being accepted this clk.
  always_comb begin
    w_raw = CNT_W'(32'(tap_data) * 32'(SCALE));
    if (tap_data == 8'd0)
      w_raw = CNT_W'(32'd256 * 32'(SCALE));
    if (r_state == EXT2)
      w_raw = CNT_W'({tap_data, r_len[15:0]});
    w_len = (w_raw < CNT_W'(2)) ? CNT_W'(2) : w_raw;
  end

  // High half takes the extra cycle of an odd length.
  assign w_hi   = r_len - (r_len >> 1);
  assign w_tick = ce & ~motor_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_cass  <= 1'b1;
    end else if (!play) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_cass  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: begin
          if (tap_valid) begin
            if (tap_data == 8'd0 && tap_ver1) begin
              r_len   <= '0;
              r_state <= EXT0;
            end else begin
              r_len   <= w_len;
              r_cnt   <= w_len >> 1;
              r_cass  <= 1'b0;
              r_state <= RUN_LO;
            end
          end
        end
        EXT0: if (tap_valid) begin
          r_len[7:0] <= tap_data;
          r_state    <= EXT1;
        end
        EXT1: if (tap_valid) begin
          r_len[15:8] <= tap_data;
          r_state     <= EXT2;
        end
        EXT2: if (tap_valid) begin
          r_len   <= w_len;
          r_cnt   <= w_len >> 1;
          r_cass  <= 1'b0;
          r_state <= RUN_LO;
        end
        RUN_LO: if (w_tick) begin
          if (r_cnt == CNT_W'(1)) begin
            r_cnt   <= w_hi;
            r_cass  <= 1'b1;
            r_state <= RUN_HI;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RUN_HI: if (w_tick) begin
          if (r_cnt == CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= FETCH;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tap_ready = (r_state == FETCH) || (r_state == EXT0) ||
                     (r_state == EXT1)  || (r_state == EXT2);
  assign busy      = (r_state == RUN_LO) || (r_state == RUN_HI);
  assign cass_read = r_cass;
  assign sense_n   = ~play;

endmodule
